wb_ddr_arb: RTL and testbench
=============================

# wb_ddr_arb

Three-master round-robin Wishbone arbiter sharing the single DDR controller port between LM32 instruction bus, LM32 data bus and a DMA master. It sits between the masters (or the interconnect's DDR slave window) and `wb_ddr`. Grants are locked for the whole `cyc` period, so bursts are never split. A bus watchdog converts a hung slave cycle into an `err` for the owning master.

## Interface
Parameters:
- `tmo_w`, default 10: watchdog counter width; timeout fires after 2**tmo_w−1 cycles of `s_stb` without `s_ack`.

Ports. Master buses are packed as {m2,m1,m0}: m0 = lm32i, m1 = lm32d, m2 = dma.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `m_cyc_i` input 3: per-master cycle request.
- `m_stb_i` input 3: per-master strobe.
- `m_we_i` input 3: per-master write enable.
- `m_adr_i` input 96: per-master address, 32 bits each.
- `m_dat_i` input 96: per-master write data.
- `m_sel_i` input 12: per-master byte selects.
- `m_dat_o` output 32: read data, broadcast to all masters.
- `m_ack_o` output 3: per-master acknowledge.
- `m_err_o` output 3: per-master error (watchdog).
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each: slave control.
- `s_adr_o` output 32, `s_dat_o` output 32, `s_sel_o` output 4: slave address, write data and byte selects.
- `s_dat_i` input 32: slave read data.
- `s_ack_i` input 1: slave acknowledge.
- `gnt_o` output 3: one-hot current owner, 0 when idle.

## Operation
- **Request:** master k requests when `m_cyc_i[k]` is high. `stb` is not used for arbitration.
- **States:**
  - IDLE: no grant.
  - GRANT: master g owns the slave.
  - ERR: one-cycle error return.
- **IDLE → GRANT:** taken when any request is present.
  - The winner is the first requester searching upward (mod 3) from `last+1`.
  - The winner is latched into `gnt` and `last`.
- **GRANT → IDLE:** taken when `m_cyc_i[g]` falls. There is no back-to-back grant; one IDLE cycle is always inserted.
- **GRANT → ERR:** taken when the watchdog reaches 2**tmo_w−1 while `s_stb_o` is high and `s_ack_i` is low.
- **ERR → IDLE:** unconditional after one cycle. A master still holding `cyc` re-arbitrates normally.
- **Muxing in GRANT:**
  - `s_cyc/stb/we/adr/dat/sel` = master g's signals.
  - `m_ack_o[g]` = `s_ack_i`; all other acks are 0.
  - `m_dat_o` = `s_dat_i` always.
- **Gating outside GRANT:** `s_cyc_o`, `s_stb_o` and `s_we_o` are forced to 0 in IDLE and ERR.
- **ERR outputs:** `m_err_o[g]` = 1 for exactly the ERR cycle; `gnt_o` keeps g during ERR.
- **Watchdog:**
  - Clears on `s_ack_i`, on leaving GRANT, and whenever `s_stb_o` is low.
  - Increments otherwise and saturates.
- **Simultaneous events:**
  - `s_ack_i` arriving in the same cycle the watchdog hits the limit: the ack wins, and no ERR is raised.
  - Granted master dropping `cyc` while a new request arrives: the new request is handled after the IDLE cycle.

## Timing
- **Reset values:** state IDLE, `gnt_o` = 0, `last` = 2 (so m0 wins first), watchdog = 0. All `s_*` control outputs, `m_ack_o` and `m_err_o` are 0.
- **Reset mid-cycle:** the slave cycle is aborted immediately with no ack or err issued.
- **Grant latency:** request sampled at edge N → `gnt_o` and `s_cyc_o` valid after edge N+1, i.e. one cycle.
- **Combinational paths:** ack and read data are combinational pass-through, adding zero latency once granted.
- **Release:** `cyc` low at edge N → IDLE after N+1 → earliest next grant after N+2.
- **Fairness:** with all three requesting continuously, the grant order is m0, m1, m2, m0, …

## Structure
- **Package `wb_arb_pkg`:** state encoding (IDLE=0, GRANT=1, ERR=2), master index constants (`M_LM32I`=0, `M_LM32D`=1, `M_DMA`=2) and `N_MASTERS`=3.
- **Sub-module `wb_rr_pick`:** combinational round-robin picker.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: `win[1:0]`, `any`.
- **Top level:** holds the FSM, the watchdog counter and the muxes.

## Test plan
- **Reset then single request:** m1 `cyc`+`stb` read, slave acks after 3 cycles with 0xDEADBEEF → `gnt_o`=010 one cycle after the request; `m_ack_o`=010 with `m_dat_o`=0xDEADBEEF; no ack to m0/m2.
- **Round-robin:** all three hold `cyc` and drop it after one acked access each, then re-request → grants m0, m1, m2, m0 with one IDLE cycle between each.
- **Burst lock:** m0 holds `cyc` for 4 acked stb beats while m2 requests → m2 is not granted until two cycles after m0's `cyc` falls.
- **Watchdog:** tmo_w=4, slave never acks m2 → `m_err_o`=100 exactly at cycle 15 of stb, `s_cyc_o`=0 that cycle, then IDLE.
- **Ack/timeout race:** ack asserted in the cycle the watchdog reaches 15 → ack delivered, no err.
- **Reset mid-cycle:** `rst` during an m1 write → next cycle all outputs are 0, and the first grant after reset goes to m0.

Source files
------------

// File: rtl/wb_ddr_arb_pkg.sv
// wb_arb_pkg: shared definitions for the wb_ddr_arb DDR port arbiter.
//   - arb_state_t    : arbiter FSM state encoding (IDLE / GRANT / ERR)
//   - M_LM32I/D, M_DMA: master index constants (bit position in packed buses)
//   - N_MASTERS      : number of arbitrated masters
//   - idx_to_onehot  : master index -> one-hot grant vector
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } arb_state_t;

  localparam int N_MASTERS = 3;

  localparam logic [1:0] M_LM32I = 2'd0;
  localparam logic [1:0] M_LM32D = 2'd1;
  localparam logic [1:0] M_DMA   = 2'd2;

  function automatic logic [N_MASTERS-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [N_MASTERS-1:0] oh;
    case (idx)
      M_LM32I: oh = 3'b001;
      M_LM32D: oh = 3'b010;
      M_DMA:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wb_ddr_arb_rr_pick.sv
// wb_rr_pick: combinational three-way round-robin picker.
//   req  [2:0] : per-master request vector
//   last [1:0] : index of the most recently granted master
//   win  [1:0] : first requester found searching upward (mod 3) from last+1
//   any        : at least one request present (win is meaningless otherwise)
import wb_arb_pkg::*;

module wb_rr_pick (
  input  logic [N_MASTERS-1:0] req,
  input  logic [1:0]           last,
  output logic [1:0]           win,
  output logic                 any
);

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    any = |req;
    win = M_LM32I;
    case (last)
      M_LM32I: begin
        if (req[1])      win = M_LM32D;
        else if (req[2]) win = M_DMA;
        else             win = M_LM32I;
      end
      M_LM32D: begin
        if (req[2])      win = M_DMA;
        else if (req[0]) win = M_LM32I;
        else             win = M_LM32D;
      end
      default: begin
        // last == M_DMA (and the unused code 3) restart from m0
        if (req[0])      win = M_LM32I;
        else if (req[1]) win = M_LM32D;
        else             win = M_DMA;
      end
    endcase
  end

endmodule

// File: rtl/wb_ddr_arb.sv
// wb_ddr_arb: three-master round-robin Wishbone arbiter in front of the
// single DDR controller port. Grants are held for the whole cyc period so
// bursts are never split; one idle cycle separates consecutive grants.
// A watchdog turns a hung slave cycle into a one-cycle err to the owner.
//   clk, rst          : clock, synchronous active-high reset
//   m_cyc/stb/we_i    : per-master control, packed {m2,m1,m0}
//   m_adr/dat/sel_i   : per-master address, write data, byte selects
//   m_dat_o           : slave read data broadcast to all masters
//   m_ack_o, m_err_o  : per-master acknowledge / watchdog error
//   s_*_o             : muxed slave bus (control forced low when not granted)
//   s_dat_i, s_ack_i  : slave read data / acknowledge
//   gnt_o             : one-hot current owner, 0 when idle
import wb_arb_pkg::*;

module wb_ddr_arb #(
  parameter int tmo_w = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*32-1:0] m_adr_i,
  input  logic [N_MASTERS*32-1:0] m_dat_i,
  input  logic [N_MASTERS*4-1:0]  m_sel_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    gnt_o
);

  localparam logic [tmo_w-1:0] WD_LIM  = {tmo_w{1'b1}};
  localparam logic [tmo_w-1:0] WD_ONE  = {{(tmo_w-1){1'b0}}, 1'b1};
  // The count reaches WD_LIM on the edge that ends the last tolerated cycle,
  // so the trip decision is made while the register still holds WD_LIM-1.
  localparam logic [tmo_w-1:0] WD_TRIP = WD_LIM - WD_ONE;

  arb_state_t             state_r, state_nxt_s;
  logic [1:0]             gidx_r, gidx_nxt_s;
  logic [1:0]             last_r, last_nxt_s;
  logic [N_MASTERS-1:0]   gnt_r, gnt_nxt_s;
  logic [tmo_w-1:0]       wdog_r, wdog_nxt_s;

  logic [1:0]             win_s;
  logic                   any_s;
  logic                   in_grant_s;
  logic                   timeout_s;
  logic                   cyc_g_s, stb_g_s, we_g_s;
  logic [31:0]            adr_g_s, dat_g_s;
  logic [3:0]             sel_g_s;

  wb_rr_pick u_pick (
    .req  (m_cyc_i),
    .last (last_r),
    .win  (win_s),
    .any  (any_s)
  );

  // Select the owning master's bus fields.
  always_comb begin
    cyc_g_s = 1'b0;
    stb_g_s = 1'b0;
    we_g_s  = 1'b0;
    adr_g_s = 32'd0;
    dat_g_s = 32'd0;
    sel_g_s = 4'd0;
    case (gidx_r)
      M_LM32I: begin
        cyc_g_s = m_cyc_i[0];
        stb_g_s = m_stb_i[0];
        we_g_s  = m_we_i[0];
        adr_g_s = m_adr_i[31:0];
        dat_g_s = m_dat_i[31:0];
        sel_g_s = m_sel_i[3:0];
      end
      M_LM32D: begin
        cyc_g_s = m_cyc_i[1];
        stb_g_s = m_stb_i[1];
        we_g_s  = m_we_i[1];
        adr_g_s = m_adr_i[63:32];
        dat_g_s = m_dat_i[63:32];
        sel_g_s = m_sel_i[7:4];
      end
      M_DMA: begin
        cyc_g_s = m_cyc_i[2];
        stb_g_s = m_stb_i[2];
        we_g_s  = m_we_i[2];
        adr_g_s = m_adr_i[95:64];
        dat_g_s = m_dat_i[95:64];
        sel_g_s = m_sel_i[11:8];
      end
      default: begin
        cyc_g_s = 1'b0;
      end
    endcase
  end

  assign in_grant_s = (state_r == ST_GRANT);

  // Everything on the slave side is quiet unless a grant is live.
  assign s_cyc_o = in_grant_s & cyc_g_s;
  assign s_stb_o = in_grant_s & stb_g_s;
  assign s_we_o  = in_grant_s & we_g_s;
  assign s_adr_o = in_grant_s ? adr_g_s : 32'd0;
  assign s_dat_o = in_grant_s ? dat_g_s : 32'd0;
  assign s_sel_o = in_grant_s ? sel_g_s : 4'd0;

  // Ack and read data are pure pass-through: no added latency once granted.
  assign m_dat_o = s_dat_i;
  assign m_ack_o = (in_grant_s && s_ack_i) ? gnt_r : 3'b000;
  assign m_err_o = (state_r == ST_ERR) ? gnt_r : 3'b000;
  assign gnt_o   = gnt_r;

  // A same-cycle ack beats the timeout.
  assign timeout_s = s_stb_o & ~s_ack_i & (wdog_r == WD_TRIP);

  // Arbiter next-state, grant latch and round-robin pointer update.
  always_comb begin
    state_nxt_s = state_r;
    gidx_nxt_s  = gidx_r;
    last_nxt_s  = last_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_nxt_s = ST_GRANT;
          gidx_nxt_s  = win_s;
          last_nxt_s  = win_s;
          gnt_nxt_s   = idx_to_onehot(win_s);
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = 3'b000;
        end
      end
      ST_GRANT: begin
        if (!cyc_g_s) begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = 3'b000;
        end else if (timeout_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_ERR: begin
        // gnt stays on the owner for the err cycle, then drops
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 3'b000;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 3'b000;
      end
    endcase
  end

  // Watchdog: count unacknowledged strobe cycles of the current grant.
  always_comb begin
    if (!in_grant_s || (state_nxt_s != ST_GRANT)) begin
      wdog_nxt_s = {tmo_w{1'b0}};
    end else if (s_ack_i || !s_stb_o) begin
      wdog_nxt_s = {tmo_w{1'b0}};
    end else if (wdog_r == WD_LIM) begin
      wdog_nxt_s = wdog_r;
    end else begin
      wdog_nxt_s = wdog_r + WD_ONE;
    end
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gidx_r  <= M_LM32I;
      last_r  <= M_DMA;
      gnt_r   <= 3'b000;
      wdog_r  <= {tmo_w{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      gidx_r  <= gidx_nxt_s;
      last_r  <= last_nxt_s;
      gnt_r   <= gnt_nxt_s;
      wdog_r  <= wdog_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_ddr_arb.sv
// tb_wb_ddr_arb: directed bench for wb_ddr_arb (tmo_w = 4, timeout at 15).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_wb_ddr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [95:0] m_adr_i, m_dat_i;
  logic [11:0] m_sel_i;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [2:0]  gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_ddr_arb #(.tmo_w(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_adr_i[k*32 +: 32] = adr;
    m_dat_i[k*32 +: 32] = dat;
    m_sel_i[k*4 +: 4]   = sel;
  endtask

  task automatic drop_m(input int k);
    drive_m(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drop_m(k);
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    step();
    rst = 1'b0;
  endtask

  logic [2:0] rr_ord [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         rr_own [4] = '{0, 1, 2, 0};

  initial begin
    rst     = 1'b1;
    m_cyc_i = 3'b000;
    m_stb_i = 3'b000;
    m_we_i  = 3'b000;
    m_adr_i = 96'd0;
    m_dat_i = 96'd0;
    m_sel_i = 12'd0;
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;

    // Reset values
    step();
    step();
    settle();
    check_eq("rst_gnt",  {29'd0, gnt_o},   32'd0);
    check_eq("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
    check_eq("rst_sstb", {31'd0, s_stb_o}, 32'd0);
    check_eq("rst_ack",  {29'd0, m_ack_o}, 32'd0);
    check_eq("rst_err",  {29'd0, m_err_o}, 32'd0);
    rst = 1'b0;

    // Single m1 read, slave acks in the third granted cycle
    step();
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'hF);
    settle();
    check_eq("t1_pre_gnt", {29'd0, gnt_o}, 32'd0);
    step(); settle();
    check_eq("t1_gnt",  {29'd0, gnt_o},   32'd2);
    check_eq("t1_scyc", {31'd0, s_cyc_o}, 32'd1);
    check_eq("t1_sstb", {31'd0, s_stb_o}, 32'd1);
    check_eq("t1_swe",  {31'd0, s_we_o},  32'd0);
    check_eq("t1_sadr", s_adr_o,          32'h0000_1000);
    check_eq("t1_ssel", {28'd0, s_sel_o}, 32'hF);
    check_eq("t1_ack0", {29'd0, m_ack_o}, 32'd0);
    step(); settle();
    check_eq("t1_ack1", {29'd0, m_ack_o}, 32'd0);
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    settle();
    check_eq("t1_ack",  {29'd0, m_ack_o}, 32'd2);
    check_eq("t1_rdat", m_dat_o,          32'hDEAD_BEEF);
    step();
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    drop_m(1);
    settle();
    check_eq("t1_ack_off", {29'd0, m_ack_o}, 32'd0);
    check_eq("t1_scyc_off", {31'd0, s_cyc_o}, 32'd0);
    check_eq("t1_gnt_hold", {29'd0, gnt_o},  32'd2);
    step(); settle();
    check_eq("t1_idle", {29'd0, gnt_o}, 32'd0);

    // Round-robin with all three requesting
    do_reset();
    step();
    for (int k = 0; k < 3; k++) drive_m(k, 1'b1, 1'b1, 1'b0, 32'h100 + k, 32'd0, 4'hF);
    settle();
    check_eq("rr_pre", {29'd0, gnt_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      s_ack_i = 1'b1;
      settle();
      check_eq("rr_gnt", {29'd0, gnt_o},   {29'd0, rr_ord[i]});
      check_eq("rr_ack", {29'd0, m_ack_o}, {29'd0, rr_ord[i]});
      check_eq("rr_adr", s_adr_o,          32'h100 + rr_own[i]);
      step();
      s_ack_i = 1'b0;
      drop_m(rr_own[i]);
      settle();
      check_eq("rr_hold", {29'd0, gnt_o},   {29'd0, rr_ord[i]});
      check_eq("rr_scyc", {31'd0, s_cyc_o}, 32'd0);
      step();
      drive_m(rr_own[i], 1'b1, 1'b1, 1'b0, 32'h100 + rr_own[i], 32'd0, 4'hF);
      settle();
      check_eq("rr_idle", {29'd0, gnt_o}, 32'd0);
    end

    // Burst lock: m0 four acked beats while m2 waits
    do_reset();
    step();
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'hA5A5_0000, 4'h3);
    settle();
    step();
    drive_m(2, 1'b1, 1'b1, 1'b0, 32'h3000, 32'd0, 4'hF);
    settle();
    check_eq("bl_gnt", {29'd0, gnt_o},   32'd1);
    check_eq("bl_swe", {31'd0, s_we_o},  32'd1);
    check_eq("bl_sdat", s_dat_o,         32'hA5A5_0000);
    for (int b = 0; b < 4; b++) begin
      step();
      s_ack_i = 1'b1;
      drive_m(0, 1'b1, 1'b1, 1'b1, 32'h2000 + 4 * b, 32'hA5A5_0000 + b, 4'h3);
      settle();
      check_eq("bl_ack", {29'd0, m_ack_o}, 32'd1);
      check_eq("bl_lock", {29'd0, gnt_o},  32'd1);
    end
    step();
    s_ack_i = 1'b0;
    drop_m(0);
    settle();
    check_eq("bl_drop_gnt", {29'd0, gnt_o},   32'd1);
    check_eq("bl_drop_ack", {29'd0, m_ack_o}, 32'd0);
    step(); settle();
    check_eq("bl_idle", {29'd0, gnt_o}, 32'd0);
    step(); settle();
    check_eq("bl_m2_gnt", {29'd0, gnt_o}, 32'd4);
    check_eq("bl_m2_adr", s_adr_o,        32'h3000);

    // Watchdog: m2 never acked; stb cycle 0 was the one just checked
    for (int k = 1; k < 15; k++) begin
      step(); settle();
      check_eq("wd_noerr", {29'd0, m_err_o}, 32'd0);
      check_eq("wd_scyc",  {31'd0, s_cyc_o}, 32'd1);
    end
    step(); settle();
    check_eq("wd_err",     {29'd0, m_err_o}, 32'd4);
    check_eq("wd_err_cyc", {31'd0, s_cyc_o}, 32'd0);
    check_eq("wd_err_stb", {31'd0, s_stb_o}, 32'd0);
    check_eq("wd_err_gnt", {29'd0, gnt_o},   32'd4);
    step(); settle();
    check_eq("wd_idle_gnt", {29'd0, gnt_o},   32'd0);
    check_eq("wd_idle_err", {29'd0, m_err_o}, 32'd0);
    step(); settle();
    check_eq("wd_regrant", {29'd0, gnt_o}, 32'd4);

    // Ack arriving in the cycle that would otherwise trip the watchdog
    for (int k = 1; k < 14; k++) begin
      step(); settle();
    end
    step();
    s_ack_i = 1'b1;
    settle();
    check_eq("race_ack", {29'd0, m_ack_o}, 32'd4);
    check_eq("race_err", {29'd0, m_err_o}, 32'd0);
    step();
    s_ack_i = 1'b0;
    settle();
    check_eq("race_noerr", {29'd0, m_err_o}, 32'd0);
    check_eq("race_gnt",   {29'd0, gnt_o},   32'd4);
    step();
    drop_m(2);
    settle();
    step(); settle();
    check_eq("race_idle", {29'd0, gnt_o}, 32'd0);

    // Reset in the middle of an m1 write
    step();
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h4000, 32'hCAFE_F00D, 4'hC);
    settle();
    step(); settle();
    check_eq("mr_gnt",  {29'd0, gnt_o},   32'd2);
    check_eq("mr_swe",  {31'd0, s_we_o},  32'd1);
    check_eq("mr_sdat", s_dat_o,          32'hCAFE_F00D);
    check_eq("mr_ssel", {28'd0, s_sel_o}, 32'hC);
    step();
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h5000, 32'd0, 4'hF);
    drive_m(2, 1'b1, 1'b1, 1'b0, 32'h6000, 32'd0, 4'hF);
    settle();
    step();
    s_ack_i = 1'b1;
    settle();
    check_eq("mr_rst_gnt",  {29'd0, gnt_o},   32'd0);
    check_eq("mr_rst_scyc", {31'd0, s_cyc_o}, 32'd0);
    check_eq("mr_rst_sstb", {31'd0, s_stb_o}, 32'd0);
    check_eq("mr_rst_swe",  {31'd0, s_we_o},  32'd0);
    check_eq("mr_rst_sadr", s_adr_o,          32'd0);
    check_eq("mr_rst_sdat", s_dat_o,          32'd0);
    check_eq("mr_rst_ssel", {28'd0, s_sel_o}, 32'd0);
    check_eq("mr_rst_ack",  {29'd0, m_ack_o}, 32'd0);
    check_eq("mr_rst_err",  {29'd0, m_err_o}, 32'd0);
    rst     = 1'b0;
    s_ack_i = 1'b0;
    step(); settle();
    check_eq("mr_first_gnt", {29'd0, gnt_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
